// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: latches retiring instructions, waits for load data,
// and drives the register-file write port (also the decode bypass source).
module mem_wb_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_dst_reg,
    input  logic [1:0]            in_wb_sel,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_pc_plus2,
    input  logic                  in_halt,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  WriteReg,
    output logic [REG_ADDR_W-1:0] DstReg,
    output logic [DATA_W-1:0]     DstData,
    output logic                  halted,
    output logic [CNT_W-1:0]      retired_count
);

    // state    | meaning
    // EMPTY    | no instruction held
    // FULL     | instruction latched, writeback data resolved
    // WAIT_MEM | load latched, waiting for mem_rvalid
    // HALTED   | HLT retired, sticky until reset
    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_FULL     = 2'd1,
        S_WAIT_MEM = 2'd2,
        S_HALTED   = 2'd3
    } state_t;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PCS  = 2'b10;
    localparam logic [1:0] WB_RSVD = 2'b11;

    state_t                  state;
    state_t                  state_nxt;
    logic                    lat_reg_write;
    logic [REG_ADDR_W-1:0]   lat_dst;
    logic                    lat_halt;
    logic                    capture;
    logic                    cap_write;
    logic [DATA_W-1:0]       cap_data;
    logic                    load_done;

    // A HALT in FULL retires into HALTED, so nothing is captured behind it.
    assign capture   = in_valid && (state == S_EMPTY || (state == S_FULL && !lat_halt));
    assign cap_write = in_reg_write && (in_wb_sel != WB_RSVD) && !in_halt;
    assign load_done = (state == S_WAIT_MEM) && mem_rvalid;

    always_comb begin
        cap_data = in_alu_result;
        if (in_wb_sel == WB_PCS) begin
            cap_data = in_pc_plus2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: begin
                if (in_valid) begin
                    state_nxt = (in_wb_sel == WB_MEM) ? S_WAIT_MEM : S_FULL;
                end
            end
            S_FULL: begin
                if (lat_halt) begin
                    state_nxt = S_HALTED;
                end else if (in_valid) begin
                    state_nxt = (in_wb_sel == WB_MEM) ? S_WAIT_MEM : S_FULL;
                end else begin
                    state_nxt = S_EMPTY;
                end
            end
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_nxt = S_FULL;
                end
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        in_ready = (state == S_EMPTY) || (state == S_FULL);
        halted   = (state == S_HALTED);
    end

    // WriteReg is registered and only ever set on an edge that enters FULL,
    // so it is high for exactly the one FULL cycle of each writing instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_reg_write <= 1'b0;
            lat_dst       <= '0;
            lat_halt      <= 1'b0;
            WriteReg      <= 1'b0;
            DstReg        <= '0;
            DstData       <= '0;
            retired_count <= '0;
        end else begin
            WriteReg <= 1'b0;
            if (capture) begin
                lat_reg_write <= cap_write;
                lat_dst       <= in_dst_reg;
                lat_halt      <= in_halt;
                if (in_wb_sel != WB_MEM && cap_write && in_dst_reg != '0) begin
                    WriteReg <= 1'b1;
                    DstReg   <= in_dst_reg;
                    DstData  <= cap_data;
                end
            end else if (load_done) begin
                if (lat_reg_write && lat_dst != '0) begin
                    WriteReg <= 1'b1;
                    DstReg   <= lat_dst;
                    DstData  <= mem_rdata;
                end
            end
            if (state == S_FULL && !(&retired_count)) begin
                retired_count <= retired_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU, back-to-back, load wait, PCS/reserved,
// halt, and asynchronous reset during a pending load.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic [3:0]  in_dst_reg;
    logic [1:0]  in_wb_sel;
    logic [15:0] in_alu_result;
    logic [15:0] in_pc_plus2;
    logic        in_halt;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic        halted;
    logic [15:0] retired_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_writes;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_write  (in_reg_write),
        .in_dst_reg    (in_dst_reg),
        .in_wb_sel     (in_wb_sel),
        .in_alu_result (in_alu_result),
        .in_pc_plus2   (in_pc_plus2),
        .in_halt       (in_halt),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid),
        .WriteReg      (WriteReg),
        .DstReg        (DstReg),
        .DstData       (DstData),
        .halted        (halted),
        .retired_count (retired_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_reg_write  = 1'b0;
        in_dst_reg    = 4'd0;
        in_wb_sel     = 2'b00;
        in_alu_result = 16'h0;
        in_pc_plus2   = 16'h0;
        in_halt       = 1'b0;
        mem_rdata     = 16'h0;
        mem_rvalid    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [3:0] dst, input logic [15:0] alu,
                         input logic [15:0] pc2, input logic wr, input logic hlt);
        in_valid      = 1'b1;
        in_wb_sel     = sel;
        in_dst_reg    = dst;
        in_alu_result = alu;
        in_pc_plus2   = pc2;
        in_reg_write  = wr;
        in_halt       = hlt;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_wr",    WriteReg, 0);
        check("rst_dst",   DstReg, 0);
        check("rst_data",  DstData, 0);
        check("rst_halt",  halted, 0);
        check("rst_cnt",   retired_count, 0);
        check("rst_ready", in_ready, 1);

        // Single ALU op
        drive(2'b00, 4'd3, 16'hDEAD, 16'h0, 1'b1, 1'b0);
        step();
        idle_inputs();
        check("alu_wr",   WriteReg, 1);
        check("alu_dst",  DstReg, 3);
        check("alu_data", DstData, 16'hDEAD);
        step();
        check("alu_wr_off", WriteReg, 0);
        check("alu_cnt",    retired_count, 1);
        check("alu_hold",   DstData, 16'hDEAD);

        // Back-to-back, dst 0..15
        do_reset();
        n_writes = 0;
        for (int i = 0; i < 16; i++) begin
            drive(2'b00, 4'(i), (i % 2 == 0) ? 16'hDEAD : 16'hBEEF, 16'h0, 1'b1, 1'b0);
            step();
            check("b2b_ready", in_ready, 1);
            check("b2b_wr", WriteReg, (i != 0) ? 1 : 0);
            if (WriteReg) n_writes++;
            if (i != 0) begin
                check("b2b_dst",  DstReg, i);
                check("b2b_data", DstData, (i % 2 == 0) ? 16'hDEAD : 16'hBEEF);
            end
        end
        idle_inputs();
        step();
        check("b2b_nwrites", n_writes, 15);
        check("b2b_wr_off",  WriteReg, 0);
        check("b2b_cnt",     retired_count, 16);

        // Load with 3-cycle wait; rvalid on the capture edge must be ignored
        do_reset();
        drive(2'b01, 4'd5, 16'h1111, 16'h0, 1'b1, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBAD0;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check("ld_wait_ready", in_ready, 0);
            check("ld_wait_wr",    WriteReg, 0);
            if (i < 2) step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h1234;
        step();
        idle_inputs();
        check("ld_wr",    WriteReg, 1);
        check("ld_dst",   DstReg, 5);
        check("ld_data",  DstData, 16'h1234);
        check("ld_ready", in_ready, 1);
        step();
        check("ld_wr_off", WriteReg, 0);
        check("ld_cnt",    retired_count, 1);

        // PCS then reserved wb_sel
        do_reset();
        drive(2'b10, 4'd15, 16'h1111, 16'h0042, 1'b1, 1'b0);
        step();
        check("pcs_wr",   WriteReg, 1);
        check("pcs_dst",  DstReg, 15);
        check("pcs_data", DstData, 16'h0042);
        drive(2'b11, 4'd7, 16'h5555, 16'h6666, 1'b1, 1'b0);
        step();
        idle_inputs();
        check("rsv_wr",   WriteReg, 0);
        check("rsv_hold", DstData, 16'h0042);
        check("rsv_cnt1", retired_count, 1);
        step();
        check("rsv_cnt2", retired_count, 2);

        // ALU to R2 then HLT
        do_reset();
        drive(2'b00, 4'd2, 16'h00A5, 16'h0, 1'b1, 1'b0);
        step();
        check("hlt_r2_wr",   WriteReg, 1);
        check("hlt_r2_data", DstData, 16'h00A5);
        drive(2'b00, 4'd4, 16'h7777, 16'h0, 1'b1, 1'b1);
        step();
        drive(2'b00, 4'd6, 16'h9999, 16'h0, 1'b1, 1'b0);
        check("hlt_no_wr", WriteReg, 0);
        check("hlt_cnt1",  retired_count, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("hlt_halted", halted, 1);
            check("hlt_ready",  in_ready, 0);
            check("hlt_wr",     WriteReg, 0);
            check("hlt_cnt",    retired_count, 2);
        end
        idle_inputs();

        // Asynchronous reset while a load is pending
        do_reset();
        drive(2'b01, 4'd9, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        idle_inputs();
        step();
        check("arst_pre_ready", in_ready, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_ready_now", in_ready, 1);
        #1 rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hFFFF;
        step();
        idle_inputs();
        check("arst_wr",     WriteReg, 0);
        check("arst_ready",  in_ready, 1);
        check("arst_cnt",    retired_count, 0);
        check("arst_halted", halted, 0);
        step();
        check("arst_wr2",  WriteReg, 0);
        check("arst_cnt2", retired_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
